// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXEC/MEM/WB sequencer with retire counter and trap.
// Optional memory-wait watchdog: define MULTICYCLE_CTRL_MEM_TIMEOUT_EN.  Rev 1.0
`default_nettype none

module multicycle_control #(
  parameter int ALU_OP_W       = 2,
  parameter int RETIRE_W       = 32,
  parameter int TIMEOUT_W      = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          opcode,
  input  logic                mem_ready,
  input  logic                alu_zero,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                i_or_d,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                branch,
  output logic                RegWrite,
  output logic [1:0]          MemtoReg,
  output logic                alu_src,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                trap,
  output logic [RETIRE_W-1:0] retired
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [6:0]          opcode_q;
  logic [RETIRE_W-1:0] retired_q;
  logic [1:0]          alu_op_lo;
  logic                wd_expired;
  logic                is_legal;

  if (ALU_OP_W < 2 || TIMEOUT_CYCLES >= 2**TIMEOUT_W) begin : g_param_check
    $error("multicycle_control: illegal ALU_OP_W / TIMEOUT_CYCLES setting");
  end

  always_comb begin
    is_legal = 1'b0;
    case (opcode)
      OP_R, OP_IALU, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR: is_legal = 1'b1;
      default:                                             is_legal = 1'b0;
    endcase
  end

`ifdef MULTICYCLE_CTRL_MEM_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] watchdog;

  assign wd_expired = (watchdog == TIMEOUT_W'(TIMEOUT_CYCLES));

  // Restart the count on every fresh entry into a memory-wait state.
  always_ff @(posedge clk) begin
    if (rst) begin
      watchdog <= '0;
    end else if ((state_next == S_FETCH || state_next == S_MEM) && state_next != state) begin
      watchdog <= '0;
    end else if ((state == S_FETCH || state == S_MEM) && !mem_ready) begin
      watchdog <= watchdog + 1'b1;
    end
  end
`else
  assign wd_expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      opcode_q  <= '0;
      retired_q <= '0;
    end else begin
      state <= state_next;
      if (state == S_DECODE) begin
        opcode_q <= opcode;
      end
      if (state_next == S_FETCH && state != S_FETCH) begin
        retired_q <= retired_q + 1'b1;
      end
    end
  end

  assign retired = rst ? '0 : retired_q;

  always_comb begin
    state_next = state;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    branch     = 1'b0;
    RegWrite   = 1'b0;
    MemtoReg   = 2'b00;
    alu_src    = 1'b0;
    alu_op_lo  = 2'b00;
    trap       = 1'b0;
    alu_op     = '0;

    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = S_DECODE;
        end else if (wd_expired) begin
          state_next = S_TRAP;
        end
      end
      S_DECODE: begin
        state_next = is_legal ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        case (opcode_q)
          OP_R: begin
            alu_op_lo  = 2'b10;
            state_next = S_WB;
          end
          OP_IALU: begin
            alu_src    = 1'b1;
            alu_op_lo  = 2'b11;
            state_next = S_WB;
          end
          OP_LD, OP_ST: begin
            alu_src    = 1'b1;
            state_next = S_MEM;
          end
          OP_BR: begin
            branch     = 1'b1;
            alu_op_lo  = 2'b01;
            pc_write   = alu_zero;
            pc_src     = 2'b01;
            state_next = S_FETCH;
          end
          OP_JAL: begin
            pc_write   = 1'b1;
            pc_src     = 2'b01;
            state_next = S_WB;
          end
          OP_JALR: begin
            alu_src    = 1'b1;
            pc_write   = 1'b1;
            pc_src     = 2'b10;
            state_next = S_WB;
          end
          default: state_next = S_TRAP;
        endcase
      end
      S_MEM: begin
        i_or_d   = 1'b1;
        MemRead  = (opcode_q == OP_LD);
        MemWrite = (opcode_q == OP_ST);
        if (mem_ready) begin
          state_next = (opcode_q == OP_LD) ? S_WB : S_FETCH;
        end else if (wd_expired) begin
          state_next = S_TRAP;
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        if (opcode_q == OP_LD) begin
          MemtoReg = 2'b01;
        end else if (opcode_q == OP_JAL || opcode_q == OP_JALR) begin
          MemtoReg = 2'b10;
        end
        state_next = S_FETCH;
      end
      S_TRAP: begin
        trap = 1'b1;
      end
      default: state_next = S_FETCH;
    endcase

    // Reset dominates every strobe, including a request already in flight.
    if (rst) begin
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      i_or_d    = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      pc_src    = 2'b00;
      branch    = 1'b0;
      RegWrite  = 1'b0;
      MemtoReg  = 2'b00;
      alu_src   = 1'b0;
      alu_op_lo = 2'b00;
      trap      = 1'b0;
    end
    alu_op[1:0] = alu_op_lo;
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: plans each instruction's expected cycle sequence and compares per cycle.
`default_nettype none

module tb_multicycle_control;

  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [6:0]    opcode;
  logic          mem_ready;
  logic          alu_zero;
  logic          MemRead, MemWrite, i_or_d, ir_write, pc_write, branch, RegWrite, alu_src, trap;
  logic [1:0]    pc_src, MemtoReg, alu_op;
  logic [RW-1:0] retired;

  int            checks = 0;
  int            errors = 0;
  int            model_ret = 0;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  multicycle_control #(
    .ALU_OP_W(2), .RETIRE_W(RW), .TIMEOUT_W(4), .TIMEOUT_CYCLES(15)
  ) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .alu_zero(alu_zero),
    .MemRead(MemRead), .MemWrite(MemWrite), .i_or_d(i_or_d), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .branch(branch), .RegWrite(RegWrite),
    .MemtoReg(MemtoReg), .alu_src(alu_src), .alu_op(alu_op), .trap(trap), .retired(retired)
  );

  always #5 clk = ~clk;

  logic [15:0] out_vec;
  assign out_vec = {MemRead, MemWrite, i_or_d, ir_write, pc_write, pc_src, branch,
                    RegWrite, MemtoReg, alu_src, alu_op, trap};

  function automatic logic [15:0] ev(input logic mr, input logic mw, input logic iod,
                                     input logic irw, input logic pcw, input logic [1:0] pcs,
                                     input logic br, input logic rw, input logic [1:0] m2r,
                                     input logic asrc, input logic [1:0] aop, input logic tr);
    return {mr, mw, iod, irw, pcw, pcs, br, rw, m2r, asrc, aop, tr};
  endfunction

  function automatic bit legal(input logic [6:0] op);
    return op inside {OP_R, OP_IALU, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, compare outputs and retire count mid-cycle, advance.
  task automatic cycle(input logic [15:0] e, input logic rdy, input logic [6:0] opc,
                       input logic z, input string tag);
    mem_ready = rdy;
    opcode    = opc;
    alu_zero  = z;
    @(negedge clk);
    check_eq(tag, 32'(out_vec), 32'(e));
    check_eq({tag, "_retired"}, 32'(retired), 32'(model_ret % (1 << RW)));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    mem_ready = 1'b1;
    opcode    = 7'($urandom);
    @(negedge clk);
    check_eq("reset_outputs", 32'(out_vec), 32'd0);
    check_eq("reset_retired", 32'(retired), 32'd0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    model_ret = 0;
  endtask

  task automatic trap_hold(input int n);
    for (int i = 0; i < n; i++)
      cycle(ev(0,0,0,0,0,2'd0,0,0,2'd0,0,2'd0,1), 1'($urandom), 7'($urandom), 1'($urandom), "trap_hold");
  endtask

  task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input logic z);
    logic [15:0] e;
    for (int i = 0; i < fw; i++)
      cycle(ev(1,0,0,0,0,2'd0,0,0,2'd0,0,2'd0,0), 1'b0, 7'($urandom), 1'($urandom), "fetch_wait");
    cycle(ev(1,0,0,1,1,2'd0,0,0,2'd0,0,2'd0,0), 1'b1, 7'($urandom), 1'($urandom), "fetch");
    cycle(16'd0, 1'($urandom), op, 1'($urandom), "decode");
    if (!legal(op)) begin
      trap_hold(20);
      do_reset();
      return;
    end
    case (op)
      OP_R:    e = ev(0,0,0,0,0,2'd0,0,0,2'd0,0,2'd2,0);
      OP_IALU: e = ev(0,0,0,0,0,2'd0,0,0,2'd0,1,2'd3,0);
      OP_LD,
      OP_ST:   e = ev(0,0,0,0,0,2'd0,0,0,2'd0,1,2'd0,0);
      OP_BR:   e = ev(0,0,0,0,z,2'd1,1,0,2'd0,0,2'd1,0);
      OP_JAL:  e = ev(0,0,0,0,1,2'd1,0,0,2'd0,0,2'd0,0);
      default: e = ev(0,0,0,0,1,2'd2,0,0,2'd0,1,2'd0,0);
    endcase
    cycle(e, 1'($urandom), 7'($urandom), (op == OP_BR) ? z : 1'($urandom), "exec");
    if (op == OP_BR) begin
      model_ret++;
      return;
    end
    if (op == OP_LD || op == OP_ST) begin
      e = ev(op == OP_LD, op == OP_ST, 1, 0,0,2'd0,0,0,2'd0,0,2'd0,0);
      for (int i = 0; i < mw; i++)
        cycle(e, 1'b0, 7'($urandom), 1'($urandom), "mem_wait");
      cycle(e, 1'b1, 7'($urandom), 1'($urandom), "mem_done");
      if (op == OP_ST) begin
        model_ret++;
        return;
      end
    end
    e = ev(0,0,0,0,0,2'd0,0,1, (op == OP_LD) ? 2'd1 : (op == OP_R || op == OP_IALU) ? 2'd0 : 2'd2,
           0,2'd0,0);
    cycle(e, 1'($urandom), 7'($urandom), 1'($urandom), "wb");
    model_ret++;
  endtask

  initial begin
    logic [6:0] ops [7];
    logic [6:0] op;
    ops = '{OP_R, OP_IALU, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR};
    rst = 1'b1; mem_ready = 1'b0; opcode = '0; alu_zero = 1'b0;

    do_reset();
    run_instr(OP_R,    0, 0, 1'b0);
    run_instr(OP_LD,   0, 3, 1'b0);
    run_instr(OP_ST,   1, 2, 1'b0);
    run_instr(OP_BR,   0, 0, 1'b1);
    run_instr(OP_BR,   2, 0, 1'b0);
    run_instr(OP_JAL,  0, 0, 1'b0);
    run_instr(OP_JALR, 0, 0, 1'b1);
    run_instr(OP_IALU, 3, 0, 1'b0);

`ifdef MULTICYCLE_CTRL_MEM_TIMEOUT_EN
    run_instr(OP_R, 15, 0, 1'b0);
    for (int i = 0; i < 16; i++)
      cycle(ev(1,0,0,0,0,2'd0,0,0,2'd0,0,2'd0,0), 1'b0, 7'($urandom), 1'b0, "timeout_wait");
    trap_hold(5);
    do_reset();
`else
    run_instr(OP_R, 20, 0, 1'b0);
`endif

    run_instr(7'b1111111, 0, 0, 1'b0);

    // Reset lands while a load is waiting in MEM.
    run_instr(OP_IALU, 0, 0, 1'b0);
    cycle(ev(1,0,0,1,1,2'd0,0,0,2'd0,0,2'd0,0), 1'b1, 7'($urandom), 1'b0, "mid_fetch");
    cycle(16'd0, 1'b0, OP_LD, 1'b0, "mid_decode");
    cycle(ev(0,0,0,0,0,2'd0,0,0,2'd0,1,2'd0,0), 1'b0, 7'($urandom), 1'b0, "mid_exec");
    cycle(ev(1,0,1,0,0,2'd0,0,0,2'd0,0,2'd0,0), 1'b0, 7'($urandom), 1'b0, "mid_mem");
    do_reset();
    run_instr(OP_JAL, 0, 0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(9) == 0) begin
        op = 7'($urandom);
        while (legal(op)) op = 7'($urandom);
      end else begin
        op = ops[$urandom_range(6)];
      end
      run_instr(op, $urandom_range(4), $urandom_range(4), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
